nco_voice_mixer: RTL and testbench
==================================

Name: nco_voice_mixer

Overview:
- Downstream stage of the 4-unit time-multiplexed sine NCO.
- Takes each unit's signed 18-bit sine sample as it emerges and scales it by a per-unit 8-bit level.
- Sums all units of one multiplex frame and presents one saturated 18-bit mixed sample per frame to the DAC driver through a valid/ack handshake.
- Flags clipping, sequence errors and overruns.

Parameters:
NCOMAX, 3, highest unit index; NCOMAX+1 units per frame
SEL_WIDTH, 2, width of unit select
SHIFT, 8, arithmetic right shift applied to the frame sum before saturation

Ports:
clk  input  1  system clock; all registers update on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
unit  input  SEL_WIDTH  unit index tagging nco_out
nco_out  input  18  signed sine sample from NCO for unit
smp_vld  input  1  nco_out/unit valid this cycle
lvl_we  input  1  level write enable
lvl_addr  input  SEL_WIDTH  level register index
lvl_data  input  8  unsigned level (0..255)
mix_out  output  18  signed mixed sample
mix_valid  output  1  mix_out holds an unconsumed sample
mix_ack  input  1  consumer takes mix_out this cycle (DAC strobe)
clip  output  1  sticky: a frame result saturated
frame_err  output  1  sticky: out-of-order unit seen
overrun  output  1  sticky: new result overwrote an unacked one
clr_flags  input  1  synchronous clear of clip/frame_err/overrun

Behaviour:
- Reset (reset=0, asynchronous):
  - mix_out=0, mix_valid=0, clip=frame_err=overrun=0.
  - All level registers=0, accumulator=0, pipeline valids=0, expected unit=0.
- Level registers: NCOMAX+1 x 8-bit flops.
  - lvl_we=1 writes lvl_data to level[lvl_addr] at the clock edge.
  - A sample accepted on the same edge uses the old level.
- Stage 1 (edge E1, smp_vld=1):
  - Register prod = nco_out (signed 18) x {0,level[unit]} (signed 9) -> signed 26-bit.
  - Also register unit and a stage-1 valid.
- Sequence check (at E1):
  - exp_unit starts at 0.
  - unit==exp_unit: accept; exp_unit <= (unit==NCOMAX) ? 0 : unit+1.
  - unit!=exp_unit: set frame_err, discard the frame in progress, drop the stage-1 valid for this sample, exp_unit <= 0.
  - A sample with unit==0 is never dropped: it restarts the frame. On mismatch with unit==0, frame_err is set and the sample is accepted as first of a new frame; exp_unit <= 1, or 0 if NCOMAX==0.
  - The discarded frame never produces mix_valid.
- Stage 2 (edge E2), accumulator width 26+SEL_WIDTH signed:
  - Valid with stage-1 unit==0: acc <= prod (load).
  - Otherwise valid: acc <= acc + prod.
  - Valid with stage-1 unit==NCOMAX: raise frame_done for one cycle.
- Output (edge E3, frame_done=1):
  - s = acc >>> SHIFT (arithmetic).
  - Saturate to [-131072, 131071]; set clip if saturated.
  - mix_out <= result, mix_valid <= 1.
- Latency: last sample of a frame at E1 -> mix_out/mix_valid updated at E3 (2 edges later). Continuous back-to-back frames supported with one sample per clock.
- Handshake:
  - mix_ack with mix_valid=1 and no frame_done -> mix_valid <= 0; mix_out holds its value.
  - frame_done with mix_valid=1 and mix_ack=0 -> overwrite mix_out, keep valid, set overrun.
  - frame_done with mix_ack=1 on the same edge -> new value loaded, mix_valid stays 1, no overrun.
  - mix_ack with mix_valid=0 is ignored.
- smp_vld=0 cycles: no state change; a frame may be spread over any number of cycles.
- clr_flags=1 clears the sticky flags. A flag event on the same edge wins (flag stays set).
- Reset mid-frame: the partial frame is lost; after release, output resumes only after a full frame 0..NCOMAX.

Test Plan:
- Levels all 128; frame units 0..3 each nco_out=1000 -> sum 512000 >>>8 -> mix_out=2000, mix_valid=1 exactly 2 edges after unit 3 sample; clip=0.
- Levels 255; all samples 131071 -> mix_out=131071, clip=1. All samples -131072 -> mix_out=-131072, clip=1.
- Levels {255,0,0,64}; samples {-512,7777,7777,1024} -> (-130560+65536)>>>8 = -254 -> mix_out=-254.
- Units 0,1,3 -> frame_err=1, no mix_valid. Then clean frame 0..3 (levels 128, samples 1000) -> mix_out=2000.
- Two back-to-back frames with mix_ack held 0 -> overrun=1, mix_out = second result. Repeat with mix_ack=1 on second frame_done edge -> overrun stays 0, mix_valid=1.
- Assert reset low mid-frame (after unit 1): all outputs 0 immediately. Release, send units 2,3 -> frame_err=1, no output. Full frame -> normal output.

Source files
------------

// File: rtl/nco_voice_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module   : nco_voice_mixer_if
//  Purpose  : Sample-in / mixed-sample-out bus between NCO, mixer and DAC driver.
//  Revision : 1.0
// ============================================================================
interface nco_voice_mixer_if #(
    parameter int SEL_WIDTH = 2
);
    logic [SEL_WIDTH-1:0] unit;
    logic [17:0]          nco_out;
    logic                 smp_vld;
    logic [17:0]          mix_out;
    logic                 mix_valid;
    logic                 mix_ack;

    modport master (
        output unit, nco_out, smp_vld, mix_ack,
        input  mix_out, mix_valid
    );

    modport slave (
        input  unit, nco_out, smp_vld, mix_ack,
        output mix_out, mix_valid
    );
endinterface
`default_nettype wire

// File: rtl/nco_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : nco_voice_mixer
//  Purpose  : Scales each multiplexed NCO unit by its level, sums a frame and
//             hands one saturated sample per frame to the DAC driver.
//  Revision : 1.0
// ============================================================================
module nco_voice_mixer #(
    parameter int NCOMAX    = 3,
    parameter int SEL_WIDTH = 2,
    parameter int SHIFT     = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    nco_voice_mixer_if.slave          bus,
    input  wire logic                 lvl_we,
    input  wire logic [SEL_WIDTH-1:0] lvl_addr,
    input  wire logic [7:0]           lvl_data,
    output logic                      clip,
    output logic                      frame_err,
    output logic                      overrun,
    input  wire logic                 clr_flags
);
    localparam int ACC_W = 26 + SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0]    c_last    = SEL_WIDTH'(NCOMAX);
    localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(-131072);

    logic [7:0]                r_level [0:NCOMAX];
    logic [SEL_WIDTH-1:0]      r_exp_unit;
    logic signed [25:0]        r_prod;
    logic [SEL_WIDTH-1:0]      r_s1_unit;
    logic                      r_s1_vld;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_frame_done;

    logic [7:0]                w_level;
    logic                      w_match;
    logic                      w_accept;
    logic                      w_seq_err;
    logic [SEL_WIDTH-1:0]      w_exp_next;
    logic signed [25:0]        w_smp_ext;
    logic signed [25:0]        w_lvl_ext;
    logic signed [25:0]        w_prod;
    logic signed [ACC_W-1:0]   w_prod_acc;
    logic signed [ACC_W-1:0]   w_shifted;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic [17:0]               w_mix;
    logic                      w_overrun_evt;

    // Unit 0 always (re)starts a frame, even when it arrives out of order.
    assign w_level    = (bus.unit <= c_last) ? r_level[bus.unit] : 8'd0;
    assign w_match    = (bus.unit == r_exp_unit);
    assign w_accept   = bus.smp_vld && (w_match || (bus.unit == '0));
    assign w_seq_err  = bus.smp_vld && !w_match;
    assign w_exp_next = (bus.unit == c_last) ? '0 : bus.unit + SEL_WIDTH'(1);

    assign w_smp_ext  = 26'($signed(bus.nco_out));
    assign w_lvl_ext  = 26'($signed({1'b0, w_level}));
    assign w_prod     = w_smp_ext * w_lvl_ext;
    assign w_prod_acc = ACC_W'(r_prod);

    assign w_shifted  = r_acc >>> SHIFT;
    assign w_sat_hi   = (w_shifted > c_sat_max);
    assign w_sat_lo   = (w_shifted < c_sat_min);
    assign w_mix      = w_sat_hi ? 18'h1FFFF : (w_sat_lo ? 18'h20000 : w_shifted[17:0]);
    assign w_overrun_evt = r_frame_done && bus.mix_valid && !bus.mix_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NCOMAX; i++) r_level[i] <= 8'd0;
        end else if (lvl_we && (lvl_addr <= c_last)) begin
            r_level[lvl_addr] <= lvl_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exp_unit <= '0;
            r_prod     <= '0;
            r_s1_unit  <= '0;
            r_s1_vld   <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (bus.smp_vld) begin
                r_exp_unit <= w_accept ? w_exp_next : '0;
                r_prod     <= w_prod;
                r_s1_unit  <= bus.unit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_s1_vld && (r_s1_unit == c_last);
            if (r_s1_vld) begin
                r_acc <= (r_s1_unit == '0) ? w_prod_acc : r_acc + w_prod_acc;
            end
        end
    end

    // A same-cycle ack lets a new frame result replace the old one cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mix_out   <= '0;
            bus.mix_valid <= 1'b0;
        end else if (r_frame_done) begin
            bus.mix_out   <= w_mix;
            bus.mix_valid <= 1'b1;
        end else if (bus.mix_ack && bus.mix_valid) begin
            bus.mix_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (r_frame_done && (w_sat_hi || w_sat_lo)) clip <= 1'b1;
            else if (clr_flags)                         clip <= 1'b0;
            if (w_seq_err)      frame_err <= 1'b1;
            else if (clr_flags) frame_err <= 1'b0;
            if (w_overrun_evt)  overrun <= 1'b1;
            else if (clr_flags) overrun <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nco_voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nco_voice_mixer
//  Purpose  : Directed vector table plus hand-written sequences for nco_voice_mixer.
//  Revision : 1.0
// ============================================================================
module tb_nco_voice_mixer;
    logic       clk = 1'b0;
    logic       reset;
    logic       lvl_we;
    logic [1:0] lvl_addr;
    logic [7:0] lvl_data;
    logic       clip;
    logic       frame_err;
    logic       overrun;
    logic       clr_flags;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    nco_voice_mixer_if #(.SEL_WIDTH(2)) bus ();

    nco_voice_mixer #(.NCOMAX(3), .SEL_WIDTH(2), .SHIFT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .lvl_we    (lvl_we),
        .lvl_addr  (lvl_addr),
        .lvl_data  (lvl_data),
        .clip      (clip),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_flags (clr_flags)
    );

    typedef struct packed {
        logic [3:0][7:0]  lvl;
        logic [3:0][17:0] smp;
        logic [17:0]      exp_out;
        logic             exp_clip;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int l0, input int l1, input int l2, input int l3,
                                input int s0, input int s1, input int s2, input int s3,
                                input int out, input int clp);
        vec_t v;
        v.lvl[0] = 8'(l0); v.lvl[1] = 8'(l1); v.lvl[2] = 8'(l2); v.lvl[3] = 8'(l3);
        v.smp[0] = 18'(s0); v.smp[1] = 18'(s1); v.smp[2] = 18'(s2); v.smp[3] = 18'(s3);
        v.exp_out  = 18'(out);
        v.exp_clip = clp[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic put_sample(input logic [1:0] u, input logic [17:0] s);
        @(negedge clk);
        bus.unit    = u;
        bus.nco_out = s;
        bus.smp_vld = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.smp_vld = 1'b0;
    endtask

    task automatic set_levels(input logic [3:0][7:0] l);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lvl_we   = 1'b1;
            lvl_addr = 2'(i);
            lvl_data = l[i];
        end
        @(negedge clk);
        lvl_we = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic ack_out(input string tag);
        logic [17:0] held;
        held = bus.mix_out;
        @(negedge clk);
        bus.mix_ack = 1'b1;
        @(negedge clk);
        bus.mix_ack = 1'b0;
        chk({tag, "_ack_valid"}, 32'(bus.mix_valid), 0);
        chk({tag, "_ack_hold"}, $signed(bus.mix_out), $signed(held));
    endtask

    // Sends one frame and checks mix_valid rises exactly two edges after the last sample.
    task automatic send_frame(input logic [3:0][17:0] s, input string tag);
        for (int i = 0; i < 4; i++) put_sample(2'(i), s[i]);
        idle();
        chk({tag, "_valid_e1"}, 32'(bus.mix_valid), 0);
        @(negedge clk);
        chk({tag, "_valid_e2"}, 32'(bus.mix_valid), 0);
        @(negedge clk);
        chk({tag, "_valid_e3"}, 32'(bus.mix_valid), 1);
    endtask

    logic [3:0][17:0] s1000;
    logic [3:0][17:0] s500;
    logic [3:0][7:0]  l128;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; lvl_we = 1'b0; lvl_addr = '0; lvl_data = '0; clr_flags = 1'b0;
        bus.unit = '0; bus.nco_out = '0; bus.smp_vld = 1'b0; bus.mix_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s1000[i] = 18'd1000;
            s500[i]  = 18'd500;
            l128[i]  = 8'd128;
        end

        vecs[0] = mk(128, 128, 128, 128, 1000, 1000, 1000, 1000, 2000, 0);
        vecs[1] = mk(255, 255, 255, 255, 131071, 131071, 131071, 131071, 131071, 1);
        vecs[2] = mk(255, 255, 255, 255, -131072, -131072, -131072, -131072, -131072, 1);
        vecs[3] = mk(255, 0, 0, 64, -512, 7777, 7777, 1024, -254, 0);
        vecs[4] = mk(0, 0, 0, 0, 9999, -9999, 131071, -131072, 0, 0);
        vecs[5] = mk(1, 2, 3, 4, 256, -256, 512, 1000, 20, 0);
        vecs[6] = mk(1, 0, 0, 0, -1, 5, 5, 5, -1, 0);

        repeat (3) @(negedge clk);
        chk("rst_mix_out", $signed(bus.mix_out), 0);
        chk("rst_mix_valid", 32'(bus.mix_valid), 0);
        chk("rst_clip", 32'(clip), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            pulse_clr();
            set_levels(vecs[v].lvl);
            send_frame(vecs[v].smp, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_out", v), $signed(bus.mix_out), $signed(vecs[v].exp_out));
            chk($sformatf("vec%0d_clip", v), 32'(clip), 32'(vecs[v].exp_clip));
            chk($sformatf("vec%0d_overrun", v), 32'(overrun), 0);
            ack_out($sformatf("vec%0d", v));
        end

        // Skipped unit: frame discarded, then a clean frame recovers.
        pulse_clr();
        set_levels(l128);
        put_sample(2'd0, 18'd1000);
        put_sample(2'd1, 18'd1000);
        put_sample(2'd3, 18'd1000);
        idle();
        repeat (3) @(negedge clk);
        chk("skip_frame_err", 32'(frame_err), 1);
        chk("skip_no_valid", 32'(bus.mix_valid), 0);
        send_frame(s1000, "recover");
        chk("recover_out", $signed(bus.mix_out), 2000);
        ack_out("recover");

        // Flag event on the same edge as clr_flags keeps the flag set.
        @(negedge clk);
        clr_flags = 1'b1;
        bus.unit = 2'd2; bus.nco_out = 18'd1; bus.smp_vld = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        bus.smp_vld = 1'b0;
        chk("clr_vs_event", 32'(frame_err), 1);
        pulse_clr();
        chk("clr_frame_err", 32'(frame_err), 0);

        // Back-to-back frames, no ack: second result overwrites and overrun sets.
        pulse_clr();
        for (int i = 0; i < 4; i++) put_sample(2'(i), s1000[i]);
        for (int i = 0; i < 4; i++) put_sample(2'(i), s500[i]);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("ovr_valid", 32'(bus.mix_valid), 1);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_out", $signed(bus.mix_out), 1000);
        ack_out("ovr");

        // Same, but ack coincides with the second frame_done edge.
        pulse_clr();
        chk("ovr_cleared", 32'(overrun), 0);
        for (int i = 0; i < 4; i++) put_sample(2'(i), s1000[i]);
        for (int i = 0; i < 4; i++) put_sample(2'(i), s500[i]);
        idle();
        @(negedge clk);
        bus.mix_ack = 1'b1;
        @(negedge clk);
        bus.mix_ack = 1'b0;
        chk("ackov_valid", 32'(bus.mix_valid), 1);
        chk("ackov_flag", 32'(overrun), 0);
        chk("ackov_out", $signed(bus.mix_out), 1000);

        // Reset mid-frame, with frame_err set and an output pending.
        put_sample(2'd1, 18'd7);
        put_sample(2'd0, 18'd1000);
        put_sample(2'd1, 18'd1000);
        idle();
        chk("pre_rst_frame_err", 32'(frame_err), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out", $signed(bus.mix_out), 0);
        chk("mid_rst_valid", 32'(bus.mix_valid), 0);
        chk("mid_rst_frame_err", 32'(frame_err), 0);
        chk("mid_rst_clip", 32'(clip), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        @(negedge clk);
        reset = 1'b1;
        set_levels(l128);
        put_sample(2'd2, 18'd1000);
        put_sample(2'd3, 18'd1000);
        idle();
        repeat (3) @(negedge clk);
        chk("post_rst_frame_err", 32'(frame_err), 1);
        chk("post_rst_no_valid", 32'(bus.mix_valid), 0);
        send_frame(s1000, "post_rst");
        chk("post_rst_out", $signed(bus.mix_out), 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
